// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: moves a control and a data bundle across a
// valid/ready boundary, with optional 2-entry skid buffer and synchronous flush.
module pipe_stage_reg #(
  parameter int CTRL_W     = 7,
  parameter int DATA_W     = 111,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [CTRL_W-1:0] main_ctrl_p0, main_ctrl_nxt;
  logic [DATA_W-1:0] main_data_p0, main_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl_p0, skid_ctrl_nxt;
  logic [DATA_W-1:0] skid_data_p0, skid_data_nxt;
  logic              in_xfer, out_xfer;

  // Value an emptied entry's data field takes: cleared, or left as it was.
  function automatic logic [DATA_W-1:0] drain_data(input logic [DATA_W-1:0] cur);
    return (CLEAR_DATA != 0) ? '0 : cur;
  endfunction

  assign out_valid = (state_p0 != S_EMPTY);
  assign out_ctrl  = main_ctrl_p0;
  assign out_data  = main_data_p0;
  assign occ       = state_p0;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    // Ready comes straight from a flop, cutting the out_ready -> in_ready path.
    logic rdy_p0;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdy_p0 <= 1'b1;
      else        rdy_p0 <= (state_nxt != S_FULL);
    end
    assign in_ready = rdy_p0;
  end else begin : g_noskid
    assign in_ready = (state_p0 == S_EMPTY) | out_ready;
  end

  always_comb begin
    state_nxt     = state_p0;
    main_ctrl_nxt = main_ctrl_p0;
    main_data_nxt = main_data_p0;
    skid_ctrl_nxt = skid_ctrl_p0;
    skid_data_nxt = skid_data_p0;
    if (flush) begin
      state_nxt     = S_EMPTY;
      main_ctrl_nxt = '0;
      main_data_nxt = drain_data(main_data_p0);
      skid_ctrl_nxt = '0;
      skid_data_nxt = drain_data(skid_data_p0);
    end else begin
      case (state_p0)
        S_EMPTY: begin
          if (in_xfer) begin
            state_nxt     = S_ONE;
            main_ctrl_nxt = in_ctrl;
            main_data_nxt = in_data;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_nxt = in_ctrl;
            main_data_nxt = in_data;
          end else if (in_xfer) begin
            if (SKID != 0) begin
              state_nxt     = S_FULL;
              skid_ctrl_nxt = in_ctrl;
              skid_data_nxt = in_data;
            end
          end else if (out_xfer) begin
            state_nxt     = S_EMPTY;
            main_ctrl_nxt = '0;
            main_data_nxt = drain_data(main_data_p0);
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_nxt     = S_ONE;
            main_ctrl_nxt = skid_ctrl_p0;
            main_data_nxt = skid_data_p0;
            skid_ctrl_nxt = '0;
            skid_data_nxt = drain_data(skid_data_p0);
          end
        end
        default: begin
          state_nxt     = S_EMPTY;
          main_ctrl_nxt = '0;
          skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // Stage register boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0     <= S_EMPTY;
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
    end else begin
      state_p0     <= state_nxt;
      main_ctrl_p0 <= main_ctrl_nxt;
      main_data_p0 <= main_data_nxt;
      skid_ctrl_p0 <= skid_ctrl_nxt;
      skid_data_p0 <= skid_data_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CW = 7;
  localparam int DW = 111;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic m_ir, m_ov, n_ir, n_ov, s_ir, s_ov;
  logic [CW-1:0] m_oc, n_oc, s_oc;
  logic [DW-1:0] m_od, n_od, s_od;
  logic [1:0]    m_occ, n_occ, s_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) u_main (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(m_ov), .out_ready(out_ready),
    .out_ctrl(m_oc), .out_data(m_od), .occ(m_occ));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(0)) u_nc (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(n_ov), .out_ready(out_ready),
    .out_ctrl(n_oc), .out_data(n_od), .occ(n_occ));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1)) u_s0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready),
    .out_ctrl(s_oc), .out_data(s_od), .occ(s_occ));

  typedef struct {
    logic        iv; logic [6:0] ic; logic [15:0] id; logic ordy; logic fl;
    logic        ev; logic [6:0] ec; logic [15:0] ed; logic [1:0] eo; logic er;
  } vec_t;

  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic ov, input logic [CW-1:0] oc,
                                         input logic [DW-1:0] od, input logic [1:0] oo,
                                         input logic ir);
    return {6'b0, ov, oc, od, oo, ir};
  endfunction

  task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t tv[16];
  ent_t qm[$];
  ent_t qs[$];

  initial begin
    tv[0]  = '{1'b1, 7'h01, 16'h0001, 1'b1, 1'b0, 1'b1, 7'h01, 16'h0001, 2'd1, 1'b1};
    tv[1]  = '{1'b1, 7'h02, 16'h0002, 1'b1, 1'b0, 1'b1, 7'h02, 16'h0002, 2'd1, 1'b1};
    tv[2]  = '{1'b1, 7'h03, 16'h0003, 1'b1, 1'b0, 1'b1, 7'h03, 16'h0003, 2'd1, 1'b1};
    tv[3]  = '{1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h03, 16'h0003, 2'd1, 1'b1};
    tv[4]  = '{1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0000, 2'd0, 1'b1};
    tv[5]  = '{1'b1, 7'h11, 16'h0011, 1'b0, 1'b0, 1'b1, 7'h11, 16'h0011, 2'd1, 1'b1};
    tv[6]  = '{1'b1, 7'h22, 16'h0022, 1'b0, 1'b0, 1'b1, 7'h11, 16'h0011, 2'd2, 1'b0};
    tv[7]  = '{1'b1, 7'h33, 16'h0033, 1'b0, 1'b0, 1'b1, 7'h11, 16'h0011, 2'd2, 1'b0};
    tv[8]  = '{1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 7'h22, 16'h0022, 2'd1, 1'b1};
    tv[9]  = '{1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0000, 2'd0, 1'b1};
    tv[10] = '{1'b1, 7'h7F, 16'h007F, 1'b0, 1'b0, 1'b1, 7'h7F, 16'h007F, 2'd1, 1'b1};
    tv[11] = '{1'b1, 7'h7F, 16'h007E, 1'b0, 1'b0, 1'b1, 7'h7F, 16'h007F, 2'd2, 1'b0};
    tv[12] = '{1'b1, 7'h55, 16'h0055, 1'b0, 1'b1, 1'b0, 7'h00, 16'h0000, 2'd0, 1'b1};
    tv[13] = '{1'b1, 7'h44, 16'h0044, 1'b0, 1'b0, 1'b1, 7'h44, 16'h0044, 2'd1, 1'b1};
    tv[14] = '{1'b1, 7'h55, 16'h0055, 1'b1, 1'b1, 1'b0, 7'h00, 16'h0000, 2'd0, 1'b1};
    tv[15] = '{1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 7'h00, 16'h0000, 2'd0, 1'b1};

    // Reset state of all three configurations
    do_reset();
    chk("reset_main", pack(m_ov, m_oc, m_od, m_occ, m_ir), pack(1'b0, '0, '0, 2'd0, 1'b1));
    chk("reset_nc",   pack(n_ov, n_oc, n_od, n_occ, n_ir), pack(1'b0, '0, '0, 2'd0, 1'b1));
    chk("reset_s0",   pack(s_ov, s_oc, s_od, s_occ, s_ir), pack(1'b0, '0, '0, 2'd0, 1'b1));

    // Vector table on the skid configuration
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].iv, tv[i].ic, DW'(tv[i].id), tv[i].ordy, tv[i].fl);
      step();
      chk($sformatf("vec%0d", i), pack(m_ov, m_oc, m_od, m_occ, m_ir),
          pack(tv[i].ev, tv[i].ec, DW'(tv[i].ed), tv[i].eo, tv[i].er));
    end

    // Drain with CLEAR_DATA=0 keeps data, clears ctrl
    do_reset();
    drive(1'b1, 7'h05, DW'(16'hDEAD), 1'b0, 1'b0);
    step();
    chk("nc_load", pack(n_ov, n_oc, n_od, n_occ, n_ir), pack(1'b1, 7'h05, DW'(16'hDEAD), 2'd1, 1'b1));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("nc_drain", pack(n_ov, n_oc, n_od, n_occ, n_ir), pack(1'b0, '0, DW'(16'hDEAD), 2'd0, 1'b1));
    chk("cd_drain", pack(m_ov, m_oc, m_od, m_occ, m_ir), pack(1'b0, '0, '0, 2'd0, 1'b1));
    drive(1'b1, 7'h06, DW'(16'hBEEF), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    chk("nc_flush", pack(n_ov, n_oc, n_od, n_occ, n_ir), pack(1'b0, '0, DW'(16'hBEEF), 2'd0, 1'b1));

    // SKID=0: out_ready pattern 1,0,1 with continuous input, 20 bundles
    do_reset();
    begin
      int cnt, nexp, got;
      cnt = 1; nexp = 1; got = 0;
      for (int i = 0; i < 100 && got < 20; i++) begin
        drive(cnt <= 20, CW'(cnt), DW'(cnt), (i % 3) != 1, 1'b0);
        #2;
        if (s_occ == 2'd1) chk("s0_ready_mirror", 128'(s_ir), 128'(out_ready));
        if (s_ov && out_ready) begin
          chk("s0_order", s_od, DW'(nexp));
          nexp++;
          got++;
        end
        if (in_valid && s_ir) cnt++;
        step();
      end
      chk("s0_count", 128'(got), 128'd20);
    end

    // Asynchronous reset while FULL
    do_reset();
    drive(1'b1, 7'h7F, DW'(1), 1'b0, 1'b0);
    step();
    drive(1'b1, 7'h7F, DW'(2), 1'b0, 1'b0);
    step();
    chk("fill_full", 128'(m_occ), 128'd2);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset", pack(m_ov, m_oc, m_od, m_occ, m_ir), pack(1'b0, '0, '0, 2'd0, 1'b1));
    #2;
    reset = 1'b1;

    // Randomized run against queue models
    do_reset();
    qm.delete();
    qs.delete();
    for (int i = 0; i < 400; i++) begin
      logic ev_m, ev_s, er_m, er_s;
      ent_t fm, fs;
      drive(($urandom % 4) != 0, CW'($urandom),
            DW'({$urandom, $urandom, $urandom, $urandom}),
            ($urandom % 3) != 0, ($urandom % 16) == 0);
      #2;
      ev_m = (qm.size() != 0);
      ev_s = (qs.size() != 0);
      fm   = ev_m ? qm[0] : '0;
      fs   = ev_s ? qs[0] : '0;
      er_m = (qm.size() < 2);
      er_s = (qs.size() == 0) || out_ready;
      chk($sformatf("rand_main%0d", i), pack(m_ov, m_oc, m_od, m_occ, m_ir),
          pack(ev_m, fm.c, fm.d, 2'(qm.size()), er_m));
      chk($sformatf("rand_s0_%0d", i), pack(s_ov, s_oc, s_od, s_occ, s_ir),
          pack(ev_s, fs.c, fs.d, 2'(qs.size()), er_s));
      if (flush) begin
        qm.delete();
        qs.delete();
      end else begin
        if (ev_m && out_ready) void'(qm.pop_front());
        if (ev_s && out_ready) void'(qs.pop_front());
        if (in_valid && er_m) qm.push_back('{in_ctrl, in_data});
        if (in_valid && er_s) qs.push_back('{in_ctrl, in_data});
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
